regfile_wb_scoreboard: RTL and testbench

//  Owns the single write port of reg_file and tracks in-flight destination registers.

---
 rtl/rv_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 32 +++
 rtl/regfile_wb_scoreboard.sv | 89 ++++++++
 tb/tb_regfile_wb_scoreboard.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared register-file widths and the writeback request payload.
package rv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last wins.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant;  // 1: requester 1 was granted most recently

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    if (!reset_n) begin
      gnt = 2'b00;
    end
  end

  // Reset to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (|gnt) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Owns the reg_file write port: arbitrates two writeback sources and tracks in-flight destinations.
module regfile_wb_scoreboard
  import rv_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rs1,
  input  logic [REG_AW-1:0]   issue_rs2,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic                issue_writes_rd,
  output logic                issue_stall,
  input  logic                wb0_valid,
  input  logic [REG_AW-1:0]   wb0_rd,
  input  logic [XLEN-1:0]     wb0_data,
  output logic                wb0_ready,
  input  logic                wb1_valid,
  input  logic [REG_AW-1:0]   wb1_rd,
  input  logic [XLEN-1:0]     wb1_data,
  output logic                wb1_ready,
  output logic                rf_write,
  output logic [REG_AW-1:0]   rf_rd,
  output logic [XLEN-1:0]     rf_writedata,
  output logic [NUM_REGS-1:0] busy,
  output logic                idle,
  output logic                proto_err
);

  logic [1:0]          gnt;
  wb_req_t             sel;
  logic                accept;
  logic                wr_fire;
  logic                issue_fire;
  logic [NUM_REGS-1:0] busy_nxt;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({wb1_valid, wb0_valid}),
    .gnt     (gnt)
  );

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];

  // Request mux and hazard/issue qualification.
  always_comb begin
    sel         = gnt[1] ? {wb1_rd, wb1_data} : {wb0_rd, wb0_data};
    accept      = |gnt;
    wr_fire     = accept && (sel.rd != '0);
    issue_stall = issue_valid &&
                  (busy[issue_rs1] || busy[issue_rs2] || (issue_writes_rd && busy[issue_rd]));
    issue_fire  = issue_valid && !issue_stall && issue_writes_rd && (issue_rd != '0);
    idle        = (busy == '0) && !rf_write;
  end

  // Clear on retiring write, then set on issue so a new producer wins the same edge.
  always_comb begin
    busy_nxt = busy;
    if (rf_write) begin
      busy_nxt[rf_rd] = 1'b0;
    end
    if (issue_fire) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_write     <= 1'b0;
      rf_rd        <= '0;
      rf_writedata <= '0;
      busy         <= '0;
      proto_err    <= 1'b0;
    end else begin
      rf_write <= wr_fire;
      if (wr_fire) begin
        rf_rd        <= sel.rd;
        rf_writedata <= sel.data;
      end
      busy <= busy_nxt;
      if (wr_fire && !busy[sel.rd]) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed and random checks of regfile_wb_scoreboard against a register-set reference model.
module tb_regfile_wb_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        issue_valid, issue_writes_rd, issue_stall;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        rf_write, idle, proto_err;
  logic [4:0]  rf_rd;
  logic [31:0] rf_writedata, busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit        mb[32];
  bit        m_wr;
  bit [4:0]  m_rd;
  bit [31:0] m_data;
  bit        m_perr;
  int        m_last;

  always #5 clk = ~clk;

  regfile_wb_scoreboard dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_writes_rd(issue_writes_rd), .issue_stall(issue_stall),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rf_write(rf_write), .rf_rd(rf_rd), .rf_writedata(rf_writedata),
    .busy(busy), .idle(idle), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = mb[i];
    return v;
  endfunction

  function automatic bit model_stall();
    return issue_valid && ((issue_rs1 != 0 && mb[issue_rs1]) || (issue_rs2 != 0 && mb[issue_rs2]) ||
                           (issue_writes_rd && issue_rd != 0 && mb[issue_rd]));
  endfunction

  task automatic model_reset();
    foreach (mb[i]) mb[i] = 1'b0;
    m_wr = 0; m_rd = '0; m_data = '0; m_perr = 0; m_last = 1;
  endtask

  task automatic clear_inputs();
    issue_valid = 0; issue_writes_rd = 0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    wb0_valid = 0; wb0_rd = '0; wb0_data = '0;
    wb1_valid = 0; wb1_rd = '0; wb1_data = '0;
  endtask

  // One clock: compare every output to the model, then advance the model across the edge.
  task automatic cycle(input string tag);
    int        win;
    bit        stall;
    bit [4:0]  srd;
    bit [31:0] sdat;
    bit        nb[32];
    #1;
    stall = model_stall();
    if (wb0_valid && wb1_valid) win = (m_last == 1) ? 0 : 1;
    else if (wb0_valid)         win = 0;
    else if (wb1_valid)         win = 1;
    else                        win = -1;
    chk({tag, ".stall"},  32'(issue_stall),  32'(stall));
    chk({tag, ".rdy0"},   32'(wb0_ready),    32'(win == 0));
    chk({tag, ".rdy1"},   32'(wb1_ready),    32'(win == 1));
    chk({tag, ".rfw"},    32'(rf_write),     32'(m_wr));
    chk({tag, ".rfrd"},   32'(rf_rd),        32'(m_rd));
    chk({tag, ".rfdat"},  rf_writedata,      m_data);
    chk({tag, ".busy"},   busy,              model_busy());
    chk({tag, ".idle"},   32'(idle),         32'(model_busy() == 0 && !m_wr));
    chk({tag, ".perr"},   32'(proto_err),    32'(m_perr));
    srd  = (win == 1) ? wb1_rd : wb0_rd;
    sdat = (win == 1) ? wb1_data : wb0_data;
    nb = mb;
    if (m_wr) nb[m_rd] = 1'b0;
    if (issue_valid && !stall && issue_writes_rd && issue_rd != 0) nb[issue_rd] = 1'b1;
    @(posedge clk);
    if (win >= 0) begin
      if (srd != 0 && !mb[srd]) m_perr = 1;
      m_last = win;
    end
    m_wr = (win >= 0) && (srd != 0);
    if (m_wr) begin
      m_rd = srd; m_data = sdat;
    end
    mb = nb;
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".busy"}, busy, 32'h0);
    chk({tag, ".rfw"},  32'(rf_write), 32'h0);
    chk({tag, ".perr"}, 32'(proto_err), 32'h0);
    chk({tag, ".idle"}, 32'(idle), 32'h1);
    chk({tag, ".rdy0"}, 32'(wb0_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
  endtask

  function automatic logic [4:0] pick_rd();
    int q[$];
    for (int i = 1; i < 32; i++) if (mb[i]) q.push_back(i);
    if (q.size() > 0 && $urandom_range(0, 9) < 8) return 5'(q[$urandom_range(0, q.size() - 1)]);
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    int w0rd[4] = '{1, 3, 3, 3};
    int w1rd[4] = '{2, 2, 4, 4};
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset("rst0");

    // Basic issue / writeback of x5
    issue_valid = 1; issue_writes_rd = 1; issue_rd = 5;
    cycle("i5");
    clear_inputs();
    chk("i5.busy5", 32'(busy[5]), 32'h1);
    wb0_valid = 1; wb0_rd = 5; wb0_data = 32'hDEAD_BEEF;
    cycle("wb5");
    clear_inputs();
    chk("wb5.rfw", 32'(rf_write), 32'h1);
    chk("wb5.rfrd", 32'(rf_rd), 32'h5);
    chk("wb5.dat", rf_writedata, 32'hDEAD_BEEF);
    cycle("wb5b");
    chk("wb5.clr", 32'(busy[5]), 32'h0);

    // RAW on x7: stall through the rf_write cycle, issue the cycle after
    issue_valid = 1; issue_writes_rd = 1; issue_rd = 7;
    cycle("i7");
    issue_writes_rd = 0; issue_rd = 0; issue_rs1 = 7;
    wb0_valid = 1; wb0_rd = 7; wb0_data = 32'h0000_0777;
    #1 chk("raw.s0", 32'(issue_stall), 32'h1);
    cycle("raw0");
    wb0_valid = 0;
    #1 chk("raw.s1", 32'(issue_stall), 32'h1);
    chk("raw.wr", 32'(rf_write), 32'h1);
    cycle("raw1");
    #1 chk("raw.s2", 32'(issue_stall), 32'h0);
    cycle("raw2");
    issue_rs1 = 0;
    #1 chk("raw.x0", 32'(issue_stall), 32'h0);
    cycle("raw3");
    clear_inputs();

    // Set and clear of x9 on the same edge; later WAW issue stalls
    wb1_valid = 1; wb1_rd = 9; wb1_data = 32'h9999_0009;
    cycle("sim0");
    clear_inputs();
    issue_valid = 1; issue_writes_rd = 1; issue_rd = 9;
    #1 chk("sim.nostall", 32'(issue_stall), 32'h0);
    chk("sim.rfrd", 32'(rf_rd), 32'h9);
    cycle("sim1");
    #1 chk("sim.busy9", 32'(busy[9]), 32'h1);
    chk("waw.stall", 32'(issue_stall), 32'h1);
    cycle("waw");
    clear_inputs();

    // Asynchronous reset with wb0 pending
    wb0_valid = 1; wb0_rd = 9; wb0_data = 32'h1234_5678;
    do_reset("rst1");

    // Contention: wb0/wb1 alternate while both are valid
    for (int k = 1; k <= 4; k++) begin
      issue_valid = 1; issue_writes_rd = 1; issue_rd = 5'(k);
      cycle("cissue");
    end
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      wb0_valid = 1; wb0_rd = 5'(w0rd[k]); wb0_data = 32'(32'hA000_0000 + k);
      wb1_valid = 1; wb1_rd = 5'(w1rd[k]); wb1_data = 32'(32'hB000_0000 + k);
      #1 chk("cont.g0", 32'(wb0_ready), 32'((k % 2) == 0));
      chk("cont.g1", 32'(wb1_ready), 32'((k % 2) == 1));
      if (k > 0) chk("cont.rfw", 32'(rf_write), 32'h1);
      cycle("cont");
    end
    clear_inputs();
    chk("cont.rfw4", 32'(rf_write), 32'h1);
    chk("cont.rd4", 32'(rf_rd), 32'h4);
    cycle("cont_end");
    cycle("cont_end2");

    // x0 writeback and protocol error
    wb1_valid = 1; wb1_rd = 0; wb1_data = 32'hFFFF_FFFF;
    #1 chk("x0.rdy", 32'(wb1_ready), 32'h1);
    cycle("x0");
    clear_inputs();
    chk("x0.rfw", 32'(rf_write), 32'h0);
    chk("x0.perr", 32'(proto_err), 32'h0);
    wb0_valid = 1; wb0_rd = 12; wb0_data = 32'h0000_00CC;
    cycle("pe0");
    clear_inputs();
    chk("pe.set", 32'(proto_err), 32'h1);
    for (int k = 0; k < 3; k++) cycle("pe_hold");
    chk("pe.stay", 32'(proto_err), 32'h1);

    // Randomized traffic
    do_reset("rst2");
    for (int n = 0; n < 400; n++) begin
      issue_valid     = ($urandom_range(0, 3) != 0);
      issue_writes_rd = $urandom_range(0, 1);
      issue_rs1       = 5'($urandom_range(0, 31));
      issue_rs2       = 5'($urandom_range(0, 31));
      issue_rd        = 5'($urandom_range(0, 31));
      wb0_valid       = $urandom_range(0, 1);
      wb0_rd          = pick_rd();
      wb0_data        = $urandom;
      wb1_valid       = $urandom_range(0, 1);
      wb1_rd          = pick_rd();
      wb1_data        = $urandom;
      cycle("rnd");
    end
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
